// File: rtl/mem_ctrl_pkg.sv
// rtl/mem_ctrl_pkg.sv - shared types and funct3 encodings for the data-memory controller
package mem_ctrl_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    typedef logic [3:0] be_t;

endpackage

// File: rtl/mem_lane_align.sv
// rtl/mem_lane_align.sv - byte-lane enables, store replication, load extraction/extension
module mem_lane_align
    import mem_ctrl_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rword,
    output be_t         o_be,
    output logic [31:0] o_wdata,
    output logic [31:0] o_rdata,
    output logic        o_misalign
);

    logic [31:0] w_byte_word;
    logic [31:0] w_half_word;

    // Shift the addressed lane down to bit 0; halfwords always start on an even lane
    assign w_byte_word = i_rword >> {i_addr_lo, 3'b000};
    assign w_half_word = i_rword >> {i_addr_lo[1], 4'b0000};

    // Decode size/sign into lane enables, replicated store data and extended load data
    always_comb begin
        o_be       = 4'b0000;
        o_wdata    = i_wdata;
        o_rdata    = i_rword;
        o_misalign = 1'b0;
        case (i_funct3)
            F3_B, F3_BU: begin
                o_be    = 4'b0001 << i_addr_lo;
                o_wdata = {4{i_wdata[7:0]}};
                o_rdata = (i_funct3 == F3_B) ? {{24{w_byte_word[7]}}, w_byte_word[7:0]}
                                             : {24'd0, w_byte_word[7:0]};
            end
            F3_H, F3_HU: begin
                o_be       = i_addr_lo[1] ? 4'b1100 : 4'b0011;
                o_wdata    = {2{i_wdata[15:0]}};
                o_rdata    = (i_funct3 == F3_H) ? {{16{w_half_word[15]}}, w_half_word[15:0]}
                                                : {16'd0, w_half_word[15:0]};
                o_misalign = i_addr_lo[0];
            end
            F3_W: begin
                o_be       = 4'b1111;
                o_misalign = |i_addr_lo;
            end
            default: begin
                o_be = 4'b0000;
            end
        endcase
    end

endmodule

// File: rtl/data_mem_controller.sv
// rtl/data_mem_controller.sv - latency-controlled data RAM responder with stall/done/fault
module data_mem_controller
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 2
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_mem_read,
    input  logic        i_mem_write,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_rdata,
    output logic        o_stall,
    output logic        o_done,
    output logic        o_fault
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [31:0]     r_mem [DEPTH];
    state_t          r_state;
    state_t          w_next;
    logic [3:0]      r_cnt;
    logic [ADDR_W+1:0] r_addr;
    logic [2:0]      r_f3;
    logic [31:0]     r_wdata;
    logic            r_is_wr;
    logic [31:0]     r_rdata;
    logic            r_fault;

    logic            w_req;
    logic            w_f3_legal;
    logic            w_in_range;
    logic            w_ok;
    logic            w_accept;
    logic            w_reject;
    logic            w_commit;
    logic [2:0]      w_al_f3;
    logic [1:0]      w_al_lo;
    logic [31:0]     w_rword;
    be_t             w_be;
    logic [31:0]     w_st_data;
    logic [31:0]     w_ld_data;
    logic            w_misalign;

    assign w_req      = i_mem_read | i_mem_write;
    assign w_in_range = (i_addr[31:ADDR_W+2] == '0);

    // In IDLE the aligner checks the live request; afterwards it serves the latched access
    assign w_al_f3 = (r_state == IDLE) ? i_funct3   : r_f3;
    assign w_al_lo = (r_state == IDLE) ? i_addr[1:0] : r_addr[1:0];
    assign w_rword = r_mem[r_addr[ADDR_W+1:2]];

    mem_lane_align u_align (
        .i_funct3   (w_al_f3),
        .i_addr_lo  (w_al_lo),
        .i_wdata    (r_wdata),
        .i_rword    (w_rword),
        .o_be       (w_be),
        .o_wdata    (w_st_data),
        .o_rdata    (w_ld_data),
        .o_misalign (w_misalign)
    );

    // Unsigned sizes exist only for loads; a write wins when both strobes are high
    always_comb begin
        w_f3_legal = 1'b0;
        case (i_funct3)
            F3_B, F3_H, F3_W: w_f3_legal = 1'b1;
            F3_BU, F3_HU:     w_f3_legal = ~i_mem_write;
            default:          w_f3_legal = 1'b0;
        endcase
    end

    assign w_ok     = w_f3_legal & ~w_misalign & w_in_range;
    assign w_accept = (r_state == IDLE) & w_req & w_ok;
    assign w_reject = (r_state == IDLE) & w_req & ~w_ok;
    assign w_commit = (r_state == BUSY) & (r_cnt == 4'd0);

    assign o_stall = i_rst_n & (w_accept | (r_state == BUSY));
    assign o_done  = (r_state == RESP);
    assign o_fault = r_fault;
    assign o_rdata = r_rdata;

    // Next-state: accept in IDLE, count down in BUSY, one response cycle in RESP
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_next = BUSY;
            BUSY:    if (r_cnt == 4'd0) w_next = RESP;
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // State, latched request, wait counter, load result and fault pulse
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
            r_cnt   <= 4'd0;
            r_addr  <= '0;
            r_f3    <= 3'd0;
            r_wdata <= 32'd0;
            r_is_wr <= 1'b0;
            r_rdata <= 32'd0;
            r_fault <= 1'b0;
        end else begin
            r_state <= w_next;
            r_fault <= w_reject;
            if (w_accept) begin
                r_addr  <= i_addr[ADDR_W+1:0];
                r_f3    <= i_funct3;
                r_wdata <= i_wdata;
                r_is_wr <= i_mem_write;
                r_cnt   <= 4'(LATENCY - 1);
            end else if (r_state == BUSY && r_cnt != 4'd0) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_commit && !r_is_wr) begin
                r_rdata <= w_ld_data;
            end
        end
    end

    // Byte-enabled RAM write at the end of a store; never while reset is asserted
    always_ff @(posedge i_clk) begin
        if (i_rst_n && w_commit && r_is_wr) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i]) begin
                    r_mem[r_addr[ADDR_W+1:2]][8*i +: 8] <= w_st_data[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_data_mem_controller.sv
// tb/tb_data_mem_controller.sv - directed and random checks against a byte-level memory model
module tb_data_mem_controller;

    localparam int ADDR_W  = 10;
    localparam int LATENCY = 2;
    localparam int DEPTH   = 2 ** ADDR_W;

    logic        clk;
    logic        rst_n;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        stall;
    logic        done;
    logic        fault;

    int errors = 0;
    int checks = 0;

    logic [7:0]  bmem [int];
    logic [31:0] model_rdata;

    data_mem_controller #(.ADDR_W(ADDR_W), .LATENCY(LATENCY)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_mem_read  (mem_read),
        .i_mem_write (mem_write),
        .i_funct3    (funct3),
        .i_addr      (addr),
        .i_wdata     (wdata),
        .o_rdata     (rdata),
        .o_stall     (stall),
        .o_done      (done),
        .o_fault     (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int size_of(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic bit legal(input bit wr, input logic [2:0] f3, input logic [31:0] a);
        if (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111) return 0;
        if (wr && f3[2]) return 0;
        if ((a % size_of(f3)) != 0) return 0;
        if (a >= 32'(4 * DEPTH)) return 0;
        return 1;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a);
        logic [31:0] v;
        int n;
        n = size_of(f3);
        v = 32'd0;
        for (int i = 0; i < n; i++) v = v | (32'(bmem[int'(a) + i]) << (8 * i));
        if (!f3[2] && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
        return v;
    endfunction

    // Issue one request at #1 after a rising edge and observe LATENCY+4 cycles
    task automatic access(input string tag, input bit rd, input bit wr, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd);
        bit ok;
        int stall_n, done_n, fault_n, done_at, fault_at;
        ok = legal(wr, f3, a);
        stall_n = 0; done_n = 0; fault_n = 0; done_at = -1; fault_at = -1;
        mem_read = rd; mem_write = wr; funct3 = f3; addr = a; wdata = wd;
        for (int c = 0; c < LATENCY + 4; c++) begin
            @(negedge clk);
            if (stall) stall_n++;
            if (done)  begin done_n++;  done_at = c;  end
            if (fault) begin fault_n++; fault_at = c; end
            @(posedge clk);
            #1;
            mem_read = 1'b0; mem_write = 1'b0;
            addr = $urandom; wdata = $urandom; funct3 = 3'($urandom);
        end
        if (ok) begin
            if (wr) begin
                for (int i = 0; i < size_of(f3); i++) bmem[int'(a) + i] = 8'(wd >> (8 * i));
            end else begin
                model_rdata = model_load(f3, a);
            end
        end
        chk({tag, " stall_cycles"}, 32'(stall_n), ok ? 32'(LATENCY + 1) : 32'd0);
        chk({tag, " done_count"},   32'(done_n),  ok ? 32'd1 : 32'd0);
        chk({tag, " done_cycle"},   32'(done_at), ok ? 32'(LATENCY + 1) : 32'hFFFF_FFFF);
        chk({tag, " fault_count"},  32'(fault_n), ok ? 32'd0 : 32'd1);
        chk({tag, " fault_cycle"},  32'(fault_at), ok ? 32'hFFFF_FFFF : 32'd1);
        chk({tag, " rdata"},        rdata, model_rdata);
    endtask

    initial begin
        logic [31:0] pre;
        rst_n = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
        funct3 = 3'd0; addr = 32'd0; wdata = 32'd0;
        model_rdata = 32'd0;

        repeat (3) @(posedge clk);
        #1;
        chk("reset stall", {31'd0, stall}, 32'd0);
        chk("reset done",  {31'd0, done},  32'd0);
        chk("reset fault", {31'd0, fault}, 32'd0);
        chk("reset rdata", rdata, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Prefill words 0x00..0x5C so every later load reads known data
        for (int w = 0; w < 24; w++) begin
            pre = (w == 8) ? 32'h80F1_7F01 : (w == 12) ? 32'h1122_3344 : $urandom;
            access("prefill", 1'b0, 1'b1, 3'b010, 32'(w * 4), pre);
        end

        access("sw 0x10", 1'b0, 1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF);
        access("lw 0x10", 1'b1, 1'b0, 3'b010, 32'h10, 32'd0);
        chk("lw 0x10 const", rdata, 32'hDEAD_BEEF);

        access("lb 0x22", 1'b1, 1'b0, 3'b000, 32'h22, 32'd0);
        chk("lb const", rdata, 32'hFFFF_FFF1);
        access("lbu 0x23", 1'b1, 1'b0, 3'b100, 32'h23, 32'd0);
        chk("lbu const", rdata, 32'h0000_0080);
        access("lh 0x22", 1'b1, 1'b0, 3'b001, 32'h22, 32'd0);
        chk("lh const", rdata, 32'hFFFF_80F1);
        access("lhu 0x20", 1'b1, 1'b0, 3'b101, 32'h20, 32'd0);
        chk("lhu const", rdata, 32'h0000_7F01);

        access("sb 0x31", 1'b0, 1'b1, 3'b000, 32'h31, 32'h0000_00AA);
        access("lw 0x30 a", 1'b1, 1'b0, 3'b010, 32'h30, 32'd0);
        chk("sb merge const", rdata, 32'h1122_AA44);
        access("sh 0x32", 1'b0, 1'b1, 3'b001, 32'h32, 32'h0000_5555);
        access("lw 0x30 b", 1'b1, 1'b0, 3'b010, 32'h30, 32'd0);
        chk("sh merge const", rdata, 32'h5555_AA44);

        access("fault lw 0x6",   1'b1, 1'b0, 3'b010, 32'h6, 32'd0);
        access("fault sh 0x3",   1'b0, 1'b1, 3'b001, 32'h3, 32'hFFFF_FFFF);
        access("fault f3 011",   1'b1, 1'b0, 3'b011, 32'h10, 32'd0);
        access("fault sbu",      1'b0, 1'b1, 3'b100, 32'h10, 32'hFFFF_FFFF);
        access("fault range",    1'b1, 1'b0, 3'b010, 32'h0001_0000, 32'd0);
        access("lw 0x0 after",   1'b1, 1'b0, 3'b010, 32'h0, 32'd0);
        access("lw 0x4 after",   1'b1, 1'b0, 3'b010, 32'h4, 32'd0);

        access("rw prio sw 0x40", 1'b1, 1'b1, 3'b010, 32'h40, 32'h1234_5678);
        access("lw 0x40", 1'b1, 1'b0, 3'b010, 32'h40, 32'd0);
        chk("prio const", rdata, 32'h1234_5678);

        // Reset during BUSY aborts the store
        mem_write = 1'b1; mem_read = 1'b0; funct3 = 3'b010; addr = 32'h50; wdata = 32'hCAFE_BABE;
        @(negedge clk);
        chk("mid reset req stall", {31'd0, stall}, 32'd1);
        @(posedge clk);
        #1;
        mem_write = 1'b0; addr = 32'h0; wdata = 32'h0;
        rst_n = 1'b0;
        #1;
        chk("mid reset stall", {31'd0, stall}, 32'd0);
        chk("mid reset done",  {31'd0, done},  32'd0);
        chk("mid reset fault", {31'd0, fault}, 32'd0);
        chk("mid reset rdata", rdata, 32'd0);
        model_rdata = 32'd0;
        repeat (LATENCY + 2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        access("lw 0x50 after reset", 1'b1, 1'b0, 3'b010, 32'h50, 32'd0);
        chk("aborted store absent", {31'd0, (rdata == 32'hCAFE_BABE)}, 32'd0);

        // Random mix over the prefilled region, including illegal sizes and misalignment
        for (int n = 0; n < 60; n++) begin
            logic [1:0] dir;
            dir = 2'($urandom_range(1, 3));
            access("random", dir[0], dir[1], 3'($urandom_range(0, 7)),
                   32'($urandom_range(0, 95)), $urandom);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
